// File: rtl/led_row_scroller.sv
// led_row_scroller
// Scrolling obstacle buffer for the LED matrix. DEPTH rows of WIDTH bits
// advance one row per shift strobe, either taking a fresh row from the row
// generator or recirculating the bottom row to the top. Each row carries a
// valid bit. The bottom (player) row is checked against the player mask, and
// the first overlap is latched as a sticky collision with its mask.
module led_row_scroller #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   shift_en,
  input  logic                   rotate,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       load_row,
  input  logic [WIDTH-1:0]       play_leds,
  output logic [WIDTH*DEPTH-1:0] rows_out,
  output logic [DEPTH-1:0]       row_valid,
  output logic [WIDTH-1:0]       bottom_row,
  output logic [CW-1:0]          fill_count,
  output logic                   collision,
  output logic [WIDTH-1:0]       collision_mask
);

  logic [WIDTH-1:0] rows_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [CW-1:0]    fill_q;
  logic             collision_q;
  logic [WIDTH-1:0] mask_q;

  logic [WIDTH-1:0] overlap;
  logic             hit;

  // Overlap of the registered bottom row with the live player mask; an
  // invalid bottom row can never hit, whatever bits it holds.
  assign overlap = rows_q[DEPTH-1] & play_leds;
  assign hit     = valid_q[DEPTH-1] & (|overlap);

  // Row chain, valid tracking, fill count and sticky collision capture.
  // Priority is clear over shift over hold; the collision check runs
  // alongside the shift and sees the pre-shift bottom row.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      // NOTE: the row storage is reset on purpose: the matrix driver shows
      // rows_out directly, so stale rows after reset would be visible.
      for (int k = 0; k < DEPTH; k++) rows_q[k] <= '0;
      valid_q     <= '0;
      fill_q      <= '0;
      collision_q <= 1'b0;
      mask_q      <= '0;
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) rows_q[k] <= '0;
      valid_q     <= '0;
      fill_q      <= '0;
      collision_q <= 1'b0;
      mask_q      <= '0;
    end else begin
      if (shift_en) begin
        // NOTE: non-blocking assignments make every stage read the old value
        // of its neighbour, so the whole chain moves exactly one row.
        for (int k = 1; k < DEPTH; k++) begin
          rows_q[k]  <= rows_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
        if (rotate) begin
          rows_q[0]  <= rows_q[DEPTH-1];
          valid_q[0] <= valid_q[DEPTH-1];
        end else begin
          rows_q[0]  <= load_row;
          valid_q[0] <= 1'b1;
          if (fill_q != CW'(DEPTH)) fill_q <= fill_q + CW'(1);
        end
      end
      // Only the first collision is recorded; the mask then stays frozen.
      if (hit && !collision_q) begin
        collision_q <= 1'b1;
        mask_q      <= overlap;
      end
    end
  end

  // Flatten the row array onto the output bus, row k at [k*WIDTH +: WIDTH].
  always_comb begin
    rows_out = '0;
    for (int k = 0; k < DEPTH; k++) rows_out[k*WIDTH +: WIDTH] = rows_q[k];
  end

  assign row_valid      = valid_q;
  assign bottom_row     = rows_q[DEPTH-1];
  assign fill_count     = fill_q;
  assign collision      = collision_q;
  assign collision_mask = mask_q;

endmodule

// File: tb/tb_led_row_scroller.sv
// tb_led_row_scroller
// Directed bench with a scoreboard: the stimulus process pushes the
// hand-computed expected state after each action, and a monitor process pops
// each entry and compares it against the DUT outputs.
module tb_led_row_scroller;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clock;
  logic                   aclr;
  logic                   shift_en;
  logic                   rotate;
  logic                   clear;
  logic [WIDTH-1:0]       load_row;
  logic [WIDTH-1:0]       play_leds;
  logic [WIDTH*DEPTH-1:0] rows_out;
  logic [DEPTH-1:0]       row_valid;
  logic [WIDTH-1:0]       bottom_row;
  logic [CW-1:0]          fill_count;
  logic                   collision;
  logic [WIDTH-1:0]       collision_mask;

  led_row_scroller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .aclr           (aclr),
    .shift_en       (shift_en),
    .rotate         (rotate),
    .clear          (clear),
    .load_row       (load_row),
    .play_leds      (play_leds),
    .rows_out       (rows_out),
    .row_valid      (row_valid),
    .bottom_row     (bottom_row),
    .fill_count     (fill_count),
    .collision      (collision),
    .collision_mask (collision_mask)
  );

  typedef struct {
    string                  name;
    logic [WIDTH*DEPTH-1:0] rows;
    logic [DEPTH-1:0]       valid;
    logic [CW-1:0]          fill;
    logic                   coll;
    logic [WIDTH-1:0]       mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_pushed = 0;
  int   n_popped = 0;
  int   checks   = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pack rows given top..bottom into the rows_out layout.
  function automatic logic [WIDTH*DEPTH-1:0] pk(input logic [WIDTH-1:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic check(input string name, input logic [WIDTH*DEPTH-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic [WIDTH*DEPTH-1:0] rows,
                              input logic [DEPTH-1:0] valid, input logic [CW-1:0] fill,
                              input logic coll, input logic [WIDTH-1:0] mask);
    exp_t e;
    e.name = name; e.rows = rows; e.valid = valid; e.fill = fill;
    e.coll = coll; e.mask = mask;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Apply one cycle of inputs, then settle 1 time unit past the active edge.
  task automatic step(input logic sh, input logic rot, input logic clr,
                      input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] play);
    shift_en = sh; rotate = rot; clear = clr; load_row = ld; play_leds = play;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares each expected entry as soon as it is presented.
  initial begin
    exp_t e;
    forever begin
      wait (n_pushed > n_popped);
      e = exp_q.pop_front();
      n_popped++;
      check({e.name, ".rows"},   rows_out, e.rows);
      check({e.name, ".valid"},  {{(WIDTH*DEPTH-DEPTH){1'b0}}, row_valid}, {{(WIDTH*DEPTH-DEPTH){1'b0}}, e.valid});
      check({e.name, ".bottom"}, {{(WIDTH*DEPTH-WIDTH){1'b0}}, bottom_row}, {{(WIDTH*DEPTH-WIDTH){1'b0}}, e.rows[(DEPTH-1)*WIDTH +: WIDTH]});
      check({e.name, ".fill"},   {{(WIDTH*DEPTH-CW){1'b0}}, fill_count}, {{(WIDTH*DEPTH-CW){1'b0}}, e.fill});
      check({e.name, ".coll"},   {{(WIDTH*DEPTH-1){1'b0}}, collision}, {{(WIDTH*DEPTH-1){1'b0}}, e.coll});
      check({e.name, ".mask"},   {{(WIDTH*DEPTH-WIDTH){1'b0}}, collision_mask}, {{(WIDTH*DEPTH-WIDTH){1'b0}}, e.mask});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  localparam logic [WIDTH*DEPTH-1:0] Z = '0;

  initial begin
    aclr = 1'b0; shift_en = 1'b0; rotate = 1'b0; clear = 1'b0;
    load_row = '0; play_leds = '0;
    #2;
    expect_state("reset", Z, 4'b0000, 3'd0, 1'b0, 32'h0);
    @(negedge clock);
    aclr = 1'b1;
    step(0, 0, 0, 32'h0, 32'h0);
    expect_state("post_reset_idle", Z, 4'b0000, 3'd0, 1'b0, 32'h0);

    // Fill and scroll; the fifth shift discards the bottom row.
    step(1, 0, 0, 32'h1, 32'h0);
    expect_state("fill1", pk(32'h1, 0, 0, 0), 4'b0001, 3'd1, 1'b0, 32'h0);
    step(1, 0, 0, 32'h2, 32'h0);
    expect_state("fill2", pk(32'h2, 32'h1, 0, 0), 4'b0011, 3'd2, 1'b0, 32'h0);
    step(1, 0, 0, 32'h4, 32'h0);
    expect_state("fill3", pk(32'h4, 32'h2, 32'h1, 0), 4'b0111, 3'd3, 1'b0, 32'h0);
    step(1, 0, 0, 32'h8, 32'h0);
    expect_state("fill4", pk(32'h8, 32'h4, 32'h2, 32'h1), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(1, 0, 0, 32'h10, 32'h0);
    expect_state("fill5_sat", pk(32'h10, 32'h8, 32'h4, 32'h2), 4'b1111, 3'd4, 1'b0, 32'h0);

    // Hold: nothing moves while load_row and rotate toggle.
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 0, (i[0] ? 32'hFFFF_FFFF : 32'h5A5A_0000), 32'h0);
      expect_state("hold", pk(32'h10, 32'h8, 32'h4, 32'h2), 4'b1111, 3'd4, 1'b0, 32'h0);
    end

    // Clear beats a simultaneous shift.
    step(1, 0, 1, 32'h55, 32'h0);
    expect_state("clear_with_shift", Z, 4'b0000, 3'd0, 1'b0, 32'h0);

    // Rotate with a single valid row: valid bit travels with the data.
    step(1, 0, 0, 32'h5, 32'h0);
    expect_state("partial_load", pk(32'h5, 0, 0, 0), 4'b0001, 3'd1, 1'b0, 32'h0);
    step(1, 1, 0, 32'hFFFF, 32'h0);
    expect_state("partial_rotate", pk(0, 32'h5, 0, 0), 4'b0010, 3'd1, 1'b0, 32'h0);

    // Rotate full chain {A,B,C,D} top..bottom.
    step(0, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 32'hD, 32'h0);
    step(1, 0, 0, 32'hC, 32'h0);
    step(1, 0, 0, 32'hB, 32'h0);
    step(1, 0, 0, 32'hA, 32'h0);
    expect_state("rot_loaded", pk(32'hA, 32'hB, 32'hC, 32'hD), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(1, 1, 0, 32'hFFFF, 32'h0);
    expect_state("rot1", pk(32'hD, 32'hA, 32'hB, 32'hC), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(1, 1, 0, 32'hFFFF, 32'h0);
    expect_state("rot2", pk(32'hC, 32'hD, 32'hA, 32'hB), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(1, 1, 0, 32'hFFFF, 32'h0);
    expect_state("rot3", pk(32'hB, 32'hC, 32'hD, 32'hA), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(1, 1, 0, 32'hFFFF, 32'h0);
    expect_state("rot4", pk(32'hA, 32'hB, 32'hC, 32'hD), 4'b1111, 3'd4, 1'b0, 32'h0);

    // Invalid rows never hit, even with every player LED lit.
    step(0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'hFFFF_FFFF);
    step(0, 0, 0, 32'h0, 32'hFFFF_FFFF);
    expect_state("invalid_no_hit", Z, 4'b0000, 3'd0, 1'b0, 32'h0);

    // Collision: bottom 0xF0 against player 0x30.
    step(1, 0, 0, 32'hF0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    expect_state("coll_setup", pk(0, 0, 0, 32'hF0), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h30);
    expect_state("coll_first", pk(0, 0, 0, 32'hF0), 4'b1111, 3'd4, 1'b1, 32'h30);
    step(1, 0, 0, 32'hFF, 32'hFF);
    step(1, 0, 0, 32'h0, 32'hFF);
    step(1, 0, 0, 32'h0, 32'hFF);
    step(1, 0, 0, 32'h0, 32'hFF);
    expect_state("coll_later_ff", pk(0, 0, 0, 32'hFF), 4'b1111, 3'd4, 1'b1, 32'h30);
    step(0, 0, 0, 32'h0, 32'hFF);
    expect_state("coll_mask_sticky", pk(0, 0, 0, 32'hFF), 4'b1111, 3'd4, 1'b1, 32'h30);

    // Hit during a shift uses the pre-shift bottom row.
    step(0, 0, 1, 32'h0, 32'h0);
    expect_state("clear_coll", Z, 4'b0000, 3'd0, 1'b0, 32'h0);
    step(1, 0, 0, 32'hF0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h10);
    expect_state("hit_preshift", Z, 4'b1111, 3'd4, 1'b1, 32'h10);

    // Clear and hit in the same cycle: clear wins.
    step(0, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0F, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    expect_state("clrhit_setup", pk(0, 0, 0, 32'h0F), 4'b1111, 3'd4, 1'b0, 32'h0);
    step(0, 0, 1, 32'h0, 32'h0F);
    expect_state("clear_beats_hit", Z, 4'b0000, 3'd0, 1'b0, 32'h0);

    // Asynchronous reset mid-operation, with no clock edge in between.
    step(1, 0, 0, 32'h77, 32'h0);
    step(1, 0, 0, 32'h66, 32'h0);
    expect_state("pre_areset", pk(32'h66, 32'h77, 0, 0), 4'b0011, 3'd2, 1'b0, 32'h0);
    aclr = 1'b0;
    #1;
    expect_state("areset_immediate", Z, 4'b0000, 3'd0, 1'b0, 32'h0);
    step(1, 0, 0, 32'h99, 32'h0);
    expect_state("areset_held", Z, 4'b0000, 3'd0, 1'b0, 32'h0);
    @(negedge clock);
    aclr = 1'b1;
    step(0, 0, 0, 32'h0, 32'h0);
    expect_state("areset_release", Z, 4'b0000, 3'd0, 1'b0, 32'h0);
    step(1, 0, 0, 32'h3, 32'h0);
    expect_state("after_release_load", pk(32'h3, 0, 0, 0), 4'b0001, 3'd1, 1'b0, 32'h0);

    #2;
    checks++;
    if (n_popped != n_pushed) begin
      failures++;
      $display("FAIL scoreboard_drain: popped %0d expected %0d", n_popped, n_pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
